// File: rtl/led_disp_pkg.sv
// Shared types and page constants for the 8-LED byte display mux.
package led_disp_pkg;

  localparam int unsigned SEL_W = 4;

  typedef logic [SEL_W-1:0] page_t;

  typedef enum logic [1:0] {
    SCAN   = 2'd0,
    PAUSED = 2'd1,
    MANUAL = 2'd2
  } state_t;

  localparam page_t PAGE_A0    = 4'd0;
  localparam page_t PAGE_B0    = 4'd4;
  localparam page_t PAGE_FLAGS = 4'd8;
  localparam page_t PAGE_LAST  = 4'd8;

  // Next page in the 0..PAGE_LAST ring.
  function automatic page_t next_page(input page_t p);
    return (p >= PAGE_LAST) ? PAGE_A0 : page_t'(p + page_t'(1));
  endfunction

  // Out-of-range load requests land on the last page.
  function automatic page_t clamp_page(input page_t p);
    return (p > PAGE_LAST) ? PAGE_LAST : p;
  endfunction

endpackage

// File: rtl/edge_rise.sv
// Single-bit rising-edge detector; the delayed copy resets to RST_VAL.
module edge_rise #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise_c
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (rst) d_q <= RST_VAL;
    else     d_q <= d;
  end

  assign rise_c = d & ~d_q;

endmodule

// File: rtl/led_page_scanner.sv
// Page sequencer for the display mux: timed auto scan, pause, and manual step/load.
module led_page_scanner
  import led_disp_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = $clog2(DWELL_CYCLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             auto_en,
  input  logic             hold,
  input  logic             step,
  input  logic             load,
  input  logic [SEL_W-1:0] load_page,
  output logic [SEL_W-1:0] sel,
  output logic             page_tick,
  output logic [1:0]       state
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  page_t            sel_d;
  logic             step_rise_c;

  // A button held through reset release must not count as a press.
  edge_rise #(.RST_VAL(1'b1)) u_step_edge (
    .clk    (clk),
    .rst    (rst),
    .d      (step),
    .rise_c (step_rise_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= SCAN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel;
    case (state_q)
      SCAN: begin
        // Step and terminal count in the same cycle still give one advance.
        if (step_rise_c || (cnt_q == CNT_LAST)) begin
          cnt_d = '0;
          sel_d = next_page(sel);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        if (!auto_en)  state_d = MANUAL;
        else if (hold) state_d = PAUSED;
      end
      PAUSED: begin
        if (step_rise_c) begin
          cnt_d = '0;
          sel_d = next_page(sel);
        end
        if (!auto_en)   state_d = MANUAL;
        else if (!hold) state_d = SCAN;
      end
      MANUAL: begin
        cnt_d = '0;
        if (load)             sel_d = clamp_page(load_page);
        else if (step_rise_c) sel_d = next_page(sel);
        if (auto_en) state_d = SCAN;
      end
      default: begin
        state_d = SCAN;
        cnt_d   = '0;
      end
    endcase
  end

  // Tick only on a real change so reloading the shown page stays quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      sel       <= PAGE_A0;
      page_tick <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      sel       <= sel_d;
      page_tick <= (sel_d != sel);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_led_page_scanner.sv
// Self-checking bench for led_page_scanner against a countdown-based page model.
module tb_led_page_scanner;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       auto_en = 1'b1;
  logic       hold = 1'b0;
  logic       step = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_page = 4'd0;
  logic [3:0] sel;
  logic       page_tick;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 scan, 1 paused, 2 manual; m_left = cycles of dwell remaining.
  int m_sel = 0;
  int m_left = DWELL;
  int m_mode = 0;
  bit m_tick = 0;
  bit m_step_prev = 1;

  led_page_scanner #(.DWELL_CYCLES(DWELL)) dut (
    .clk       (clk),
    .rst       (rst),
    .auto_en   (auto_en),
    .hold      (hold),
    .step      (step),
    .load      (load),
    .load_page (load_page),
    .sel       (sel),
    .page_tick (page_tick),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic model_clk();
    int  nsel;
    bit  pressed;
    if (rst) begin
      m_sel = 0; m_left = DWELL; m_mode = 0; m_tick = 0; m_step_prev = 1;
      return;
    end
    pressed = step && !m_step_prev;
    m_step_prev = step;
    nsel = m_sel;
    if (m_mode == 0) begin
      m_left = m_left - 1;
      if (pressed || m_left == 0) begin nsel = (m_sel + 1) % 9; m_left = DWELL; end
      if (!auto_en) m_mode = 2; else if (hold) m_mode = 1;
    end else if (m_mode == 1) begin
      if (pressed) begin nsel = (m_sel + 1) % 9; m_left = DWELL; end
      if (!auto_en) m_mode = 2; else if (!hold) m_mode = 0;
    end else begin
      m_left = DWELL;
      if (load) nsel = (load_page > 8) ? 8 : int'(load_page);
      else if (pressed) nsel = (m_sel + 1) % 9;
      if (auto_en) m_mode = 0;
    end
    m_tick = (nsel != m_sel);
    m_sel = nsel;
  endtask

  task automatic clk_edge();
    @(posedge clk);
    model_clk();
    #1;
  endtask

  task automatic test_reset();
    rst = 1; auto_en = 1; hold = 0; step = 0; load = 0;
    clk_edge(); clk_edge();
    checks++;
    if ({sel, page_tick, state} !== {4'd0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset sel=%0d tick=%0b state=%0d want 0/0/0", sel, page_tick, state);
    end
    rst = 0;
  endtask

  task automatic test_auto_scan();
    int ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      clk_edge();
      if (i <= 36 && page_tick) ticks++;
      checks++;
      if (sel !== 4'((i / DWELL) % 9) || page_tick !== (i % DWELL == 0)) begin
        errors++;
        $display("FAIL auto_scan cycle %0d sel=%0d tick=%0b want %0d/%0b", i, sel, page_tick, (i / DWELL) % 9, (i % DWELL == 0));
      end
    end
    checks++;
    if (ticks != 9) begin errors++; $display("FAIL auto_ticks got %0d want 9", ticks); end
  endtask

  task automatic test_hold();
    int held;
    int guard = 0;
    while (m_left != DWELL - 2 && guard < 20) begin clk_edge(); guard++; end
    checks++;
    if (guard >= 20) begin errors++; $display("FAIL hold_align timeout left=%0d", m_left); end
    held = int'(sel);
    hold = 1;
    for (int i = 0; i < 10; i++) begin
      clk_edge();
      checks++;
      if (state !== 2'd1 || sel !== 4'(held)) begin
        errors++; $display("FAIL hold_paused cyc %0d state=%0d sel=%0d want 1/%0d", i, state, sel, held);
      end
    end
    hold = 0;
    clk_edge();
    checks++;
    if (state !== 2'd0 || sel !== 4'(held)) begin
      errors++; $display("FAIL hold_release1 state=%0d sel=%0d want 0/%0d", state, sel, held);
    end
    clk_edge();
    checks++;
    if (sel !== 4'((held + 1) % 9) || page_tick !== 1'b1) begin
      errors++; $display("FAIL hold_release2 sel=%0d tick=%0b want %0d/1", sel, page_tick, (held + 1) % 9);
    end
  endtask

  task automatic test_manual_step();
    int hi[3] = '{3, 1, 5};
    auto_en = 0;
    clk_edge();
    load = 1; load_page = 4'd0;
    clk_edge();
    load = 0;
    checks++;
    if (state !== 2'd2 || sel !== 4'd0) begin
      errors++; $display("FAIL manual_enter state=%0d sel=%0d want 2/0", state, sel);
    end
    for (int p = 0; p < 3; p++) begin
      step = 1;
      clk_edge();
      checks++;
      if (sel !== 4'(p + 1) || page_tick !== 1'b1) begin
        errors++; $display("FAIL step_pulse%0d sel=%0d tick=%0b want %0d/1", p, sel, page_tick, p + 1);
      end
      for (int c = 0; c < 2 * hi[p] - 1; c++) begin
        if (c == hi[p] - 1) step = 0;
        clk_edge();
        checks++;
        if (sel !== 4'(p + 1) || page_tick !== 1'b0) begin
          errors++; $display("FAIL step_hold%0d sel=%0d tick=%0b want %0d/0", p, sel, page_tick, p + 1);
        end
      end
      step = 0;
    end
  endtask

  task automatic test_load();
    logic [3:0] pages[4] = '{4'd6, 4'd15, 4'd8, 4'd2};
    logic [3:0] want[4]  = '{4'd6, 4'd8,  4'd8, 4'd2};
    logic       wtick[4] = '{1'b1, 1'b1,  1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      load = 1; load_page = pages[i];
      step = (i == 3);
      clk_edge();
      load = 0;
      checks++;
      if (sel !== want[i] || page_tick !== wtick[i]) begin
        errors++; $display("FAIL load%0d sel=%0d tick=%0b want %0d/%0b", i, sel, page_tick, want[i], wtick[i]);
      end
    end
    step = 0;
    clk_edge();
  endtask

  task automatic test_step_terminal();
    load = 1; load_page = 4'd3;
    clk_edge();
    load = 0; auto_en = 1;
    clk_edge();
    for (int i = 0; i < DWELL - 1; i++) clk_edge();
    step = 1;
    clk_edge();
    checks++;
    if (sel !== 4'd4 || page_tick !== 1'b1 || state !== 2'd0) begin
      errors++; $display("FAIL step_terminal sel=%0d tick=%0b state=%0d want 4/1/0", sel, page_tick, state);
    end
    for (int i = 1; i <= DWELL; i++) begin
      clk_edge();
      checks++;
      if (sel !== ((i == DWELL) ? 4'd5 : 4'd4)) begin
        errors++; $display("FAIL step_terminal_restart cyc %0d sel=%0d want %0d", i, sel, (i == DWELL) ? 5 : 4);
      end
    end
  endtask

  task automatic test_reset_cases();
    int guard = 0;
    step = 1; rst = 1;
    clk_edge();
    rst = 0;
    for (int i = 0; i < DWELL - 1; i++) clk_edge();
    checks++;
    if (sel !== 4'd0 || state !== 2'd0) begin
      errors++; $display("FAIL step_through_reset sel=%0d state=%0d want 0/0", sel, state);
    end
    step = 0;
    while (!(m_sel == 5 && m_left == 2) && guard < 60) begin clk_edge(); guard++; end
    checks++;
    if (guard >= 60 || sel !== 4'd5) begin
      errors++; $display("FAIL reset_align sel=%0d want 5", sel);
    end
    rst = 1;
    clk_edge();
    checks++;
    if ({sel, page_tick, state} !== {4'd0, 1'b0, 2'd0}) begin
      errors++; $display("FAIL reset_mid_dwell sel=%0d tick=%0b state=%0d want 0/0/0", sel, page_tick, state);
    end
    rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom % 150 == 0);
      if ($urandom % 20 == 0) auto_en = ~auto_en;
      if ($urandom % 5 == 0) hold = ~hold;
      if ($urandom % 3 == 0) step = ~step;
      load = ($urandom % 6 == 0);
      load_page = 4'($urandom % 16);
      clk_edge();
      checks++;
      if ({sel, page_tick, state} !== {4'(m_sel), m_tick, 2'(m_mode)}) begin
        errors++;
        $display("FAIL random cyc %0d sel=%0d tick=%0b state=%0d want %0d/%0b/%0d", i, sel, page_tick, state, m_sel, m_tick, m_mode);
      end
    end
    rst = 0; load = 0;
  endtask

  initial begin
    test_reset();
    test_auto_scan();
    test_hold();
    test_manual_step();
    test_load();
    test_step_terminal();
    test_reset_cases();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

endmodule
